td_fused_top_hadd_reduce_driver: RTL and testbench
==================================================

// Module: td_fused_top_hadd_reduce_driver
// PURPOSE
// Initiator side of the fp16 adder core's s_axis/m_axis interface. Consumes a stream of fp16
// values, one vector per tlast-terminated packet, and returns their sum as one fp16 beat.
// Drives the external adder core (td_fused_top_ap_hadd_*) with aclken held high and tracks
// the core's results itself, because the core's result tvalid is not trustworthy.
// Sits after the hmul core in the dot-product path.
// PARAMETERS
// ADD_LATENCY  2  cycles from issue (operands driven in cycle t) to result on add_result_tdata (cycle t+ADD_LATENCY); >=1
// PORTS
// aclk              in   1   clock, all state on rising edge
// aresetn           in   1   asynchronous active-low reset
// s_axis_tvalid     in   1   input beat valid
// s_axis_tready     out  1   input beat accepted when tvalid&tready
// s_axis_tdata      in   16  fp16 element
// s_axis_tlast      in   1   last element of vector
// m_axis_tvalid     out  1   sum valid
// m_axis_tready     in   1   downstream accepts sum
// m_axis_tdata      out  16  fp16 sum
// add_aclken        out  1   adder clock enable
// add_a_tvalid      out  1   operand A valid (== issue)
// add_a_tdata       out  16  operand A
// add_b_tvalid      out  1   operand B valid (== issue)
// add_b_tdata       out  16  operand B
// add_result_tdata  in   16  adder result, meaningful only when vld[ADD_LATENCY-1]
// BEHAVIOUR
// - Reset: state=ACCUM, vld[]=0, hold_v=0, hold=0, add_aclken=0, m_axis_tvalid=0,
//   m_axis_tdata=0, s_axis_tready=0 while aresetn low. add_aclken=1 from first edge after release.
// - vld[ADD_LATENCY-1:0]: shift register, vld[0]<=issue; emerge = vld[ADD_LATENCY-1]. Each
//   issued add is one "token" (partial sum) in flight; at most ADD_LATENCY tokens exist.
// - ACCUM: s_axis_tready=1 (once add_aclken=1).
//   - beat accepted: issue A=(emerge ? add_result_tdata : 16'h0000), B=s_axis_tdata.
//   - no beat, emerge: issue A=add_result_tdata, B=16'h0000 (recirculate; -0 becomes +0, accepted).
//   - no beat, no emerge: no issue; operands hold last value, valids 0.
//   - beat with tlast accepted -> DRAIN at next edge.
// - DRAIN: s_axis_tready=0.
//   - emerge & !hold_v: hold<=result, hold_v<=1, no issue.
//   - emerge & hold_v: issue A=hold, B=result; hold_v<=0.
//   - !emerge: no issue.
//   - m_axis_tvalid = hold_v & (vld==0), purely from registers (no input->output comb path);
//     m_axis_tdata = hold.
//   - m_axis_tvalid & m_axis_tready: hold_v<=0, -> ACCUM. tdata/tvalid stable while tready low.
// - Next vector is not accepted until the sum handshake completes.
// - Single-element vector: tlast accepted cycle 0 -> m_axis_tvalid first high cycle ADD_LATENCY+1.
// - Summation order is implementation-defined by the token scheme; results are compared with
//   exact-representable sums only.
// - Reset mid-operation: all tokens discarded via vld clear; the adder's internal contents are
//   ignored; resume in ACCUM.
// TESTING (bench uses behavioural ADD_LATENCY-stage fp16 adder; run ADD_LATENCY=2 and 6)
// 1. Single beat 16'h3C00 tlast, m_axis_tready=1 -> one beat 16'h3C00, tvalid high at cycle ADD_LATENCY+1.
// 2. Back-to-back 3C00,4000,4200,4400(tlast) -> sum 16'h4900 (10.0); exactly one output beat.
// 3. Eight 3C00 beats, tvalid toggling 1/0 randomly -> 16'h4800 (8.0); no extra or lost tokens.
// 4. Sum ready, m_axis_tready low 5 cycles -> tdata 4900 stable, s_axis_tready=0; after accept,
//    next vector accepted.
// 5. aresetn low during DRAIN of a 4-beat vector -> outputs at reset values; next vector
//    4000,4000(tlast) -> 16'h4400.
// 6. Vector with tlast beat arriving while ADD_LATENCY tokens are in flight -> correct sum;
//    add_a/b_tvalid never exceed one issue per cycle.

Source files
------------

// File: rtl/td_fused_top_hadd_reduce_driver.sv
// td_fused_top_hadd_reduce_driver
// Reduces a tlast-terminated stream of fp16 values to one fp16 sum by driving an
// external ADD_LATENCY-deep fp16 adder core. The core's result valid is not used.
// Instead, every issued add is tracked as a token in a local shift register, and a
// result is consumed only in the cycle its token emerges.
//
// Token scheme:
//   ACCUM - each accepted beat is added to an emerging partial sum, or to +0 when no
//           partial sum emerges that cycle. An emerging partial sum with no beat to
//           pair with is recirculated through the adder (x + 0). The token count
//           therefore never exceeds ADD_LATENCY.
//   DRAIN - emerging partial sums are combined pairwise through a one-entry hold
//           register until one token remains in hold and none are in flight. That
//           value is the sum.
// The adder's operand bus keeps its last value when nothing is issued.

module td_fused_top_hadd_reduce_driver #(
    parameter int ADD_LATENCY = 2
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [15:0] m_axis_tdata,
    output logic        add_aclken,
    output logic        add_a_tvalid,
    output logic [15:0] add_a_tdata,
    output logic        add_b_tvalid,
    output logic [15:0] add_b_tdata,
    input  logic [15:0] add_result_tdata
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Registered state
    state_t                   state_q,    state_d;
    logic [ADD_LATENCY-1:0]   vld_q,      vld_d;
    logic [15:0]              hold_q,     hold_d;
    logic                     hold_v_q,   hold_v_d;
    logic                     aclken_q,   aclken_d;
    logic                     s_ready_q,  s_ready_d;
    logic [15:0]              opa_q,      opa_d;
    logic [15:0]              opb_q,      opb_d;

    // Combinational helpers
    logic                     emerge_s;
    logic                     accept_s;
    logic                     no_flight_s;
    logic                     m_valid_s;
    logic                     m_fire_s;
    logic                     issue_s;
    logic [15:0]              opa_s;
    logic [15:0]              opb_s;

    // A token leaves the adder in the cycle its result sits on add_result_tdata.
    assign emerge_s    = vld_q[ADD_LATENCY-1];
    assign accept_s    = s_axis_tvalid & s_ready_q & (state_q == ST_ACCUM);
    assign no_flight_s = (vld_q == {ADD_LATENCY{1'b0}});

    // The sum is offered only from registered state, so downstream ready never
    // feeds back into valid.
    assign m_valid_s = (state_q == ST_DRAIN) & hold_v_q & no_flight_s;
    assign m_fire_s  = m_valid_s & m_axis_tready;

    // Operand selection, issue decision and next state for the token scheme
    always_comb begin
        issue_s  = 1'b0;
        opa_s    = opa_q;
        opb_s    = opb_q;
        state_d  = state_q;
        hold_d   = hold_q;
        hold_v_d = hold_v_q;
        case (state_q)
            ST_ACCUM: begin
                if (accept_s) begin
                    issue_s = 1'b1;
                    opa_s   = emerge_s ? add_result_tdata : 16'h0000;
                    opb_s   = s_axis_tdata;
                    if (s_axis_tlast) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else if (emerge_s) begin
                    // Keep the partial sum alive; x + 0 also turns -0 into +0.
                    issue_s = 1'b1;
                    opa_s   = add_result_tdata;
                    opb_s   = 16'h0000;
                end else begin
                    issue_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (emerge_s) begin
                    if (!hold_v_q) begin
                        hold_d   = add_result_tdata;
                        hold_v_d = 1'b1;
                    end else begin
                        issue_s  = 1'b1;
                        opa_s    = hold_q;
                        opb_s    = add_result_tdata;
                        hold_v_d = 1'b0;
                    end
                end else if (m_fire_s) begin
                    hold_v_d = 1'b0;
                    state_d  = ST_ACCUM;
                end else begin
                    hold_v_d = hold_v_q;
                end
            end
            default: begin
                state_d  = ST_ACCUM;
                hold_v_d = 1'b0;
            end
        endcase
    end

    // Token shift register: one bit per adder stage, entering on issue
    always_comb begin
        vld_d    = {ADD_LATENCY{1'b0}};
        vld_d[0] = issue_s;
        for (int i = 1; i < ADD_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    // Enable, input-ready and operand-bus holding values
    always_comb begin
        aclken_d  = 1'b1;
        s_ready_d = (state_d == ST_ACCUM);
        opa_d     = opa_s;
        opb_d     = opb_s;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_ACCUM;
            vld_q     <= {ADD_LATENCY{1'b0}};
            hold_q    <= 16'h0000;
            hold_v_q  <= 1'b0;
            aclken_q  <= 1'b0;
            s_ready_q <= 1'b0;
            opa_q     <= 16'h0000;
            opb_q     <= 16'h0000;
        end else begin
            state_q   <= state_d;
            vld_q     <= vld_d;
            hold_q    <= hold_d;
            hold_v_q  <= hold_v_d;
            aclken_q  <= aclken_d;
            s_ready_q <= s_ready_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
        end
    end

    assign s_axis_tready = s_ready_q;
    assign m_axis_tvalid = m_valid_s;
    assign m_axis_tdata  = hold_q;
    assign add_aclken    = aclken_q;
    assign add_a_tvalid  = issue_s;
    assign add_b_tvalid  = issue_s;
    assign add_a_tdata   = opa_s;
    assign add_b_tdata   = opb_s;

endmodule

// File: tb/tb_td_fused_top_hadd_reduce_driver.sv
// Bench for td_fused_top_hadd_reduce_driver: behavioural ADD_LATENCY-stage fp16
// adder, table-driven vectors, hand sequences for back-pressure and mid-drain reset,
// and random vectors whose sums come from a real-arithmetic reference.
module tb_td_fused_top_hadd_reduce_driver;

    localparam int TB_LAT = 2;

    logic        clk;
    logic        aresetn;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [15:0] m_axis_tdata;
    logic        add_aclken;
    logic        add_a_tvalid;
    logic [15:0] add_a_tdata;
    logic        add_b_tvalid;
    logic [15:0] add_b_tdata;
    logic [15:0] add_result_tdata;

    int n_chk  = 0;
    int n_fail = 0;
    int n_out  = 0;
    int exp_out = 0;

    td_fused_top_hadd_reduce_driver #(.ADD_LATENCY(TB_LAT)) dut (
        .aclk             (clk),
        .aresetn          (aresetn),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tlast     (s_axis_tlast),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .add_aclken       (add_aclken),
        .add_a_tvalid     (add_a_tvalid),
        .add_a_tdata      (add_a_tdata),
        .add_b_tvalid     (add_b_tvalid),
        .add_b_tdata      (add_b_tdata),
        .add_result_tdata (add_result_tdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fp16 <-> real helpers (exact for the values used here)
    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        real m;
        int  e;
        e = int'(h[14:10]);
        if (e == 0) m = real'(int'(h[9:0])) * pow2(-24);
        else        m = (1.0 + real'(int'(h[9:0])) / 1024.0) * pow2(e - 15);
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2h(input real x);
        real        m;
        int         e;
        logic       s;
        logic [4:0] ef;
        logic [9:0] ff;
        if (x == 0.0) return 16'h0000;
        s = (x < 0.0);
        m = s ? -x : x;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        ef = 5'(e + 15);
        ff = 10'($rtoi((m - 1.0) * 1024.0));
        return {s, ef, ff};
    endfunction

    // Behavioural adder core: result appears ADD_LATENCY cycles after operands
    logic [15:0] pipe [TB_LAT];
    always @(posedge clk) begin
        if (add_aclken) begin
            pipe[0] <= r2h(h2r(add_a_tdata) + h2r(add_b_tdata));
            for (int i = 1; i < TB_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign add_result_tdata = pipe[TB_LAT-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Output handshake counter
    always @(posedge clk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) n_out++;
    end

    // Issue-bus sanity: A/B valid together and only with the adder enabled
    always @(negedge clk) begin
        if (aresetn) begin
            chk("issue_pair", {31'd0, add_a_tvalid}, {31'd0, add_b_tvalid});
            if (add_a_tvalid) chk("issue_aclken", {31'd0, add_aclken}, 32'd1);
        end
    end

    // Drive a vector; returns at the negedge after the tlast beat was accepted
    task automatic send(input logic [7:0][15:0] v, input int n, input bit gaps);
        int w;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                s_axis_tvalid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = v[i];
            s_axis_tlast  = (i == n - 1);
            w = 0;
            while (!s_axis_tready && w < 200) begin @(negedge clk); w++; end
            if (w >= 200) begin
                chk("send_timeout", 32'd1, 32'd0);
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                return;
            end
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Wait for the sum, optionally hold off ready, check, then take it
    task automatic recv(input logic [15:0] exp, input string nm, input int dly, output int lat);
        lat = 0;
        while (!m_axis_tvalid && lat < 300) begin @(negedge clk); lat++; end
        if (!m_axis_tvalid) begin
            chk({nm, "_timeout"}, 32'd1, 32'd0);
            return;
        end
        chk(nm, {16'd0, m_axis_tdata}, {16'd0, exp});
        for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            chk({nm, "_hold_valid"}, {31'd0, m_axis_tvalid}, 32'd1);
            chk({nm, "_hold_data"}, {16'd0, m_axis_tdata}, {16'd0, exp});
            chk({nm, "_hold_sready"}, {31'd0, s_axis_tready}, 32'd0);
        end
        m_axis_tready = 1'b1;
        @(negedge clk);
        m_axis_tready = 1'b0;
        exp_out++;
    endtask

    typedef struct {
        int               n;
        bit               gaps;
        logic [7:0][15:0] v;
        logic [15:0]      e;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int               lat;
        logic [7:0][15:0] rv;
        real              rsum;
        int               n;
        int               val;

        tbl[0] = '{n: 1, gaps: 1'b0, v: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h3C00}, e: 16'h3C00};
        tbl[1] = '{n: 4, gaps: 1'b0, v: {16'h0, 16'h0, 16'h0, 16'h0, 16'h4400, 16'h4200, 16'h4000, 16'h3C00}, e: 16'h4900};
        tbl[2] = '{n: 8, gaps: 1'b1, v: {8{16'h3C00}}, e: 16'h4800};
        tbl[3] = '{n: 2, gaps: 1'b0, v: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h4000, 16'h4000}, e: 16'h4400};
        tbl[4] = '{n: 2, gaps: 1'b1, v: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hBC00, 16'h3C00}, e: 16'h0000};
        tbl[5] = '{n: 3, gaps: 1'b0, v: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h3800, 16'hC000, 16'h4400}, e: 16'h4100};
        tbl[6] = '{n: 8, gaps: 1'b0, v: {16'h4800, 16'h4700, 16'h4600, 16'h4500, 16'h4400, 16'h4200, 16'h4000, 16'h3C00}, e: 16'h5080};

        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 16'h0000;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_aclken", {31'd0, add_aclken}, 32'd0);
        chk("rst_sready", {31'd0, s_axis_tready}, 32'd0);
        chk("rst_mvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("rst_mdata", {16'd0, m_axis_tdata}, 32'd0);
        aresetn = 1'b1;
        @(negedge clk);
        chk("post_rst_aclken", {31'd0, add_aclken}, 32'd1);
        chk("post_rst_sready", {31'd0, s_axis_tready}, 32'd1);

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            send(tbl[i].v, tbl[i].n, tbl[i].gaps);
            recv(tbl[i].e, $sformatf("tbl%0d_sum", i), 0, lat);
            if (tbl[i].n == 1) chk("single_latency", lat, TB_LAT);
        end

        // Back-pressure: sum held 5 cycles, then next vector accepted
        send(tbl[1].v, 4, 1'b0);
        recv(16'h4900, "bp_sum", 5, lat);
        @(negedge clk);
        chk("bp_next_ready", {31'd0, s_axis_tready}, 32'd1);
        send(tbl[3].v, 2, 1'b0);
        recv(16'h4400, "bp_next_sum", 0, lat);

        // Reset during DRAIN of a 4-beat vector
        send(tbl[1].v, 4, 1'b0);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_mvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("mid_rst_mdata", {16'd0, m_axis_tdata}, 32'd0);
        chk("mid_rst_sready", {31'd0, s_axis_tready}, 32'd0);
        chk("mid_rst_aclken", {31'd0, add_aclken}, 32'd0);
        chk("mid_rst_issue", {31'd0, add_a_tvalid}, 32'd0);
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        send(tbl[3].v, 2, 1'b0);
        recv(16'h4400, "after_rst_sum", 0, lat);

        // Random vectors against a real-arithmetic sum
        for (int t = 0; t < 20; t++) begin
            n    = $urandom_range(1, 8);
            rsum = 0.0;
            rv   = '0;
            for (int k = 0; k < n; k++) begin
                val   = int'($urandom_range(0, 16)) - 8;
                rv[k] = r2h(real'(val));
                rsum  = rsum + real'(val);
            end
            send(rv, n, ($urandom_range(0, 1) == 1));
            recv(r2h(rsum), $sformatf("rand%0d_sum", t), $urandom_range(0, 3), lat);
        end

        repeat (TB_LAT + 4) @(negedge clk);
        chk("out_count", n_out, exp_out);
        chk("idle_mvalid", {31'd0, m_axis_tvalid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
